// File: rtl/sample_monitor.sv
// sample_monitor: watches the D/E outputs of the sample block, counts rising
// edges on each, measures the width of the most recent d_in high pulse and
// publishes a frozen snapshot of that activity through a req/valid/ack
// handshake. All counters saturate; any saturation sets a sticky overflow flag.
module sample_monitor #(
    parameter int CNT_W       = 8,
    parameter int WID_W       = 16,
    parameter bit CLR_ON_SNAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             e_in,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             snap_valid,
    output logic [CNT_W-1:0] d_rise_cnt,
    output logic [CNT_W-1:0] e_rise_cnt,
    output logic [WID_W-1:0] d_last_width,
    output logic             overflow,
    output logic             d_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WID_W-1:0] WID_MAX = {WID_W{1'b1}};

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state_q;
    logic               dS1_q, dS2_q, eS1_q, eS2_q;
    logic [CNT_W-1:0]   dCnt_q, dCnt_d;
    logic [CNT_W-1:0]   eCnt_q, eCnt_d;
    logic [WID_W-1:0]   wCnt_q, wCnt_d;
    logic [WID_W-1:0]   liveWidth_q, liveWidth_d;
    logic               ovf_q, ovf_d;

    logic               dRise, dFall, eRise;
    logic               snapTake, clrNow;
    logic [CNT_W-1:0]   dBase, eBase;
    logic               ovfBase;
    logic               dSat, eSat, wSat;

    assign dRise    = dS1_q & ~dS2_q;
    assign dFall    = ~dS1_q & dS2_q;
    assign eRise    = eS1_q & ~eS2_q;
    assign snapTake = (state_q == IDLE) && snap_req;
    assign clrNow   = snapTake && CLR_ON_SNAP;
    assign d_level  = dS2_q;

    // Next live values: a snapshot clear zeroes the base first, so a rise on the
    // capture edge lands in the fresh count instead of being lost.
    always_comb begin
        dBase       = clrNow ? '0 : dCnt_q;
        eBase       = clrNow ? '0 : eCnt_q;
        ovfBase     = clrNow ? 1'b0 : ovf_q;
        dCnt_d      = dBase;
        eCnt_d      = eBase;
        wCnt_d      = '0;
        dSat        = 1'b0;
        eSat        = 1'b0;
        wSat        = 1'b0;
        liveWidth_d = dFall ? wCnt_q : liveWidth_q;
        if (dRise) begin
            if (dBase == CNT_MAX) dSat = 1'b1;
            else                  dCnt_d = dBase + 1'b1;
        end
        if (eRise) begin
            if (eBase == CNT_MAX) eSat = 1'b1;
            else                  eCnt_d = eBase + 1'b1;
        end
        if (dS1_q) begin
            if (wCnt_q == WID_MAX) begin
                wCnt_d = WID_MAX;
                wSat   = 1'b1;
            end else begin
                wCnt_d = wCnt_q + 1'b1;
            end
        end
        ovf_d = ovfBase | dSat | eSat | wSat;
    end

    // Input synchronising stages and live counters; these run in every FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dS1_q       <= 1'b0;
            dS2_q       <= 1'b0;
            eS1_q       <= 1'b0;
            eS2_q       <= 1'b0;
            dCnt_q      <= '0;
            eCnt_q      <= '0;
            wCnt_q      <= '0;
            liveWidth_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            dS1_q       <= d_in;
            dS2_q       <= dS1_q;
            eS1_q       <= e_in;
            eS2_q       <= eS1_q;
            dCnt_q      <= dCnt_d;
            eCnt_q      <= eCnt_d;
            wCnt_q      <= wCnt_d;
            liveWidth_q <= liveWidth_d;
            ovf_q       <= ovf_d;
        end
    end

    // Snapshot handshake: capture pre-edge live values on a request in IDLE,
    // hold them frozen until acknowledged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            snap_valid   <= 1'b0;
            d_rise_cnt   <= '0;
            e_rise_cnt   <= '0;
            d_last_width <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (snap_req) begin
                        d_rise_cnt   <= dCnt_q;
                        e_rise_cnt   <= eCnt_q;
                        d_last_width <= liveWidth_q;
                        overflow     <= ovf_q;
                        snap_valid   <= 1'b1;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    if (snap_ack) begin
                        snap_valid <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    snap_valid <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_monitor.sv
// tb_sample_monitor: drives edge patterns into sample_monitor (CNT_W=4,
// WID_W=4 so saturation is reachable quickly), queues the snapshot each
// scenario should produce and compares it when snap_valid appears.
module tb_sample_monitor;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] e;
        logic [3:0] w;
        logic       ovf;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_in;
    logic       e_in;
    logic       snap_req;
    logic       snap_ack;
    logic       snap_valid;
    logic [3:0] d_rise_cnt;
    logic [3:0] e_rise_cnt;
    logic [3:0] d_last_width;
    logic       overflow;
    logic       d_level;

    int    checks = 0;
    int    errors = 0;
    snap_t expQ[$];

    sample_monitor #(
        .CNT_W(4),
        .WID_W(4),
        .CLR_ON_SNAP(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .d_in(d_in),
        .e_in(e_in),
        .snap_req(snap_req),
        .snap_ack(snap_ack),
        .snap_valid(snap_valid),
        .d_rise_cnt(d_rise_cnt),
        .e_rise_cnt(e_rise_cnt),
        .d_last_width(d_last_width),
        .overflow(overflow),
        .d_level(d_level)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic snap_t observed();
        snap_t s;
        s.d   = d_rise_cnt;
        s.e   = e_rise_cnt;
        s.w   = d_last_width;
        s.ovf = overflow;
        return s;
    endfunction

    task automatic pulseD(input int width, input int gap);
        d_in = 1'b1;
        tick(width);
        d_in = 1'b0;
        tick(gap);
    endtask

    task automatic pulseE(input int width, input int gap);
        e_in = 1'b1;
        tick(width);
        e_in = 1'b0;
        tick(gap);
    endtask

    // Raise snap_req for one edge and count extra edges until snap_valid.
    task automatic takeSnap(output int waitEdges);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        waitEdges = 0;
        while (!snap_valid && waitEdges < 8) begin
            tick();
            waitEdges++;
        end
    endtask

    task automatic ackSnap();
        snap_ack = 1'b1;
        tick();
        snap_ack = 1'b0;
    endtask

    task automatic test_reset();
        snap_t zero = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_in = i[0];
            e_in = ~i[0];
            snap_req = i[0];
            tick();
        end
        checks++;
        if (observed() !== zero || snap_valid !== 1'b0 || d_level !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %h valid=%b lvl=%b, required 0", observed(), snap_valid, d_level);
        end
        d_in = 1'b0;
        e_in = 1'b0;
        snap_req = 1'b0;
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (observed() !== zero || snap_valid !== 1'b0 || d_level !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h valid=%b lvl=%b, required 0", observed(), snap_valid, d_level);
        end
    endtask

    task automatic test_single_pulse();
        int    w;
        snap_t exp;
        d_in = 1'b1;
        e_in = 1'b1;
        tick(3);
        checks++;
        if (d_level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL d_level_high: got %b, required 1", d_level);
        end
        tick(7);
        d_in = 1'b0;
        e_in = 1'b0;
        tick(5);
        expQ.push_back('{d: 4'd1, e: 4'd1, w: 4'd10, ovf: 1'b0});
        takeSnap(w);
        exp = expQ.pop_front();
        checks++;
        if (w !== 0) begin
            errors++;
            $display("[TB] FAIL single_latency: got %0d extra edges, required 0", w);
        end
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("[TB] FAIL single_snap: got %h, required %h", observed(), exp);
        end
        ackSnap();
        checks++;
        if (snap_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ack: got valid=%b, required 0", snap_valid);
        end
    endtask

    task automatic test_multi_clear();
        int    w;
        snap_t exp;
        pulseD(2, 3);
        pulseD(4, 3);
        pulseD(6, 3);
        expQ.push_back('{d: 4'd3, e: 4'd0, w: 4'd6, ovf: 1'b0});
        takeSnap(w);
        exp = expQ.pop_front();
        checks++;
        if (w !== 0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL multi_snap: got %h after %0d, required %h", observed(), w, exp);
        end
        ackSnap();
        tick(2);
        expQ.push_back('{d: 4'd0, e: 4'd0, w: 4'd6, ovf: 1'b0});
        takeSnap(w);
        exp = expQ.pop_front();
        checks++;
        if (w !== 0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL multi_cleared: got %h after %0d, required %h", observed(), w, exp);
        end
        ackSnap();
    endtask

    task automatic test_saturation();
        int    w;
        snap_t exp;
        for (int i = 0; i < 20; i++) pulseE(1, 1);
        tick(3);
        expQ.push_back('{d: 4'd0, e: 4'd15, w: 4'd6, ovf: 1'b1});
        takeSnap(w);
        exp = expQ.pop_front();
        checks++;
        if (w !== 0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL e_saturate: got %h after %0d, required %h", observed(), w, exp);
        end
        ackSnap();
        tick();
        expQ.push_back('{d: 4'd0, e: 4'd0, w: 4'd6, ovf: 1'b0});
        takeSnap(w);
        exp = expQ.pop_front();
        checks++;
        if (w !== 0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL ovf_cleared: got %h after %0d, required %h", observed(), w, exp);
        end
        ackSnap();
        pulseD(20, 4);
        expQ.push_back('{d: 4'd1, e: 4'd0, w: 4'd15, ovf: 1'b1});
        takeSnap(w);
        exp = expQ.pop_front();
        checks++;
        if (w !== 0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL w_saturate: got %h after %0d, required %h", observed(), w, exp);
        end
        ackSnap();
    endtask

    task automatic test_back_to_back();
        int    w;
        snap_t exp;
        tick(2);
        d_in = 1'b1;
        tick();
        expQ.push_back('{d: 4'd0, e: 4'd0, w: 4'd15, ovf: 1'b0});
        takeSnap(w);
        d_in = 1'b0;
        exp = expQ.pop_front();
        checks++;
        if (w !== 0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL coincident_snap: got %h after %0d, required %h", observed(), w, exp);
        end
        snap_req = 1'b1;
        snap_ack = 1'b1;
        tick();
        snap_req = 1'b0;
        snap_ack = 1'b0;
        checks++;
        if (snap_valid !== 1'b0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL req_ack_hold: got valid=%b %h, required valid=0 %h", snap_valid, observed(), exp);
        end
        tick(3);
        checks++;
        if (snap_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL req_ack_idle: got valid=%b, required 0", snap_valid);
        end
        expQ.push_back('{d: 4'd1, e: 4'd0, w: 4'd2, ovf: 1'b0});
        takeSnap(w);
        exp = expQ.pop_front();
        checks++;
        if (w !== 0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL coincident_next: got %h after %0d, required %h", observed(), w, exp);
        end
        ackSnap();
        expQ.push_back('{d: 4'd0, e: 4'd0, w: 4'd2, ovf: 1'b0});
        takeSnap(w);
        exp = expQ.pop_front();
        checks++;
        if (w !== 0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL min_spacing: got %h after %0d, required %h", observed(), w, exp);
        end
        ackSnap();
    endtask

    task automatic test_reset_mid_handshake();
        int    w;
        snap_t exp;
        snap_t zero = '0;
        pulseE(2, 4);
        expQ.push_back('{d: 4'd0, e: 4'd1, w: 4'd2, ovf: 1'b0});
        takeSnap(w);
        exp = expQ.pop_front();
        checks++;
        if (w !== 0 || observed() !== exp) begin
            errors++;
            $display("[TB] FAIL pre_reset_snap: got %h after %0d, required %h", observed(), w, exp);
        end
        rst_n = 1'b0;
        snap_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (snap_valid !== 1'b0 || observed() !== zero) begin
            errors++;
            $display("[TB] FAIL mid_reset: got valid=%b %h, required valid=0 0", snap_valid, observed());
        end
        ackSnap();
        tick();
        checks++;
        if (snap_valid !== 1'b0 || observed() !== zero) begin
            errors++;
            $display("[TB] FAIL stray_ack: got valid=%b %h, required valid=0 0", snap_valid, observed());
        end
        checks++;
        if (expQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, required 0", expQ.size());
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        d_in     = 1'b0;
        e_in     = 1'b0;
        snap_req = 1'b0;
        snap_ack = 1'b0;
        #1;
        test_reset();
        test_single_pulse();
        test_multi_clear();
        test_saturation();
        test_back_to_back();
        test_reset_mid_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
